// File: rtl/transient_shaper_env_if.sv
// Transient shaper sample interface.
// Groups the per-sample strobe, audio and control inputs together with the
// shaped-output signals.
//   master : drives ena, audio_in, attack_gain, sustain_gain, sustain_cut and bypass;
//            receives audio_out, out_valid and clip
//   slave  : the shaper core side (the reverse directions)
interface transient_shaper_env_if #(
  parameter int unsigned IN_W   = 6,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned GAIN_W = 3
);
  logic              ena;
  logic [IN_W-1:0]   audio_in;
  logic [GAIN_W-1:0] attack_gain;
  logic [GAIN_W-1:0] sustain_gain;
  logic              sustain_cut;
  logic              bypass;
  logic [OUT_W-1:0]  audio_out;
  logic              out_valid;
  logic              clip;

  modport master (
    output ena, audio_in, attack_gain, sustain_gain, sustain_cut, bypass,
    input  audio_out, out_valid, clip
  );

  modport slave (
    input  ena, audio_in, attack_gain, sustain_gain, sustain_cut, bypass,
    output audio_out, out_valid, clip
  );
endinterface

// File: rtl/transient_shaper_env.sv
// Transient shaper core.
// Tracks a fast and a slow envelope of the unsigned input magnitude. The transient
// part (fast minus slow integer envelope) is boosted by attack_gain. The slow envelope
// is added or subtracted under sustain_gain. The sum is clamped to OUT_W bits.
// Pipeline: capture (N), envelope update (N+1), output register (N+2).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; clears envelopes, pipeline and outputs
//   bus  : slave side of transient_shaper_env_if
//          (ena/audio_in/gains/sustain_cut/bypass in; audio_out/out_valid/clip out)
module transient_shaper_env #(
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned FAST_SH = 2,
  parameter int unsigned SLOW_SH = 5,
  parameter int unsigned GAIN_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  transient_shaper_env_if.slave bus
);

  localparam int unsigned F     = SLOW_SH;
  localparam int unsigned E     = IN_W + F;
  localparam int unsigned P     = IN_W + GAIN_W;
  localparam int unsigned SUM_W = OUT_W + GAIN_W + 2;

  // Stage 0: captured sample and controls
  logic              v0_q,   v0_d;
  logic [IN_W-1:0]   x0_q,   x0_d;
  logic [GAIN_W-1:0] ga0_q,  ga0_d;
  logic [GAIN_W-1:0] gs0_q,  gs0_d;
  logic              cut0_q, cut0_d;
  logic              byp0_q, byp0_d;

  // Stage 1: sample/controls aligned with the freshly updated envelopes
  logic              v1_q,   v1_d;
  logic [IN_W-1:0]   x1_q,   x1_d;
  logic [GAIN_W-1:0] ga1_q,  ga1_d;
  logic [GAIN_W-1:0] gs1_q,  gs1_d;
  logic              cut1_q, cut1_d;
  logic              byp1_q, byp1_d;

  // Envelope state, fixed point with F fractional bits
  logic [E-1:0]      env_f_q, env_f_d;
  logic [E-1:0]      env_s_q, env_s_d;

  // Output registers
  logic [OUT_W-1:0]  audio_out_q, audio_out_d;
  logic              out_valid_q, out_valid_d;
  logic              clip_q,      clip_d;

  // Datapath intermediates
  logic [E-1:0]      xs;
  logic [IN_W-1:0]   fi;
  logic [IN_W-1:0]   si;
  logic [IN_W-1:0]   tr;
  logic [P-1:0]      prod_a;
  logic [P-1:0]      prod_s;
  logic [SUM_W-1:0]  at_ext;
  logic [SUM_W-1:0]  st_ext;
  logic [SUM_W-1:0]  sum;
  logic [OUT_W-1:0]  y_c;
  logic              clip_c;

  always_comb begin
    // Envelope update for the stage-0 sample. The per-step increment is
    // (xs - env)>>SH in truncated form; modular E-bit arithmetic is exact
    // because the true result always lies in [0, xs_max].
    xs      = {x0_q, {F{1'b0}}};
    env_f_d = env_f_q;
    env_s_d = env_s_q;
    if (v0_q) begin
      env_f_d = env_f_q + (xs >> FAST_SH) - (env_f_q >> FAST_SH);
      env_s_d = env_s_q + (xs >> SLOW_SH) - (env_s_q >> SLOW_SH);
    end

    // Shaping from the stage-1 sample and the post-update envelopes
    fi     = env_f_q[E-1:F];
    si     = env_s_q[E-1:F];
    tr     = (fi > si) ? (fi - si) : '0;
    prod_a = P'(tr) * P'(ga1_q);
    prod_s = P'(si) * P'(gs1_q);
    at_ext = SUM_W'(prod_a >> 1);
    st_ext = SUM_W'(prod_s >> 1);
    // Two's-complement sum; SUM_W leaves headroom so the sign bit is reliable
    sum    = SUM_W'(x1_q) + at_ext + (cut1_q ? -st_ext : st_ext);

    y_c    = '0;
    clip_c = 1'b0;
    if (byp1_q) begin
      y_c = OUT_W'(x1_q);
    end else if (sum[SUM_W-1]) begin
      y_c = '0;
    end else if (|sum[SUM_W-2:OUT_W]) begin
      y_c    = '1;
      clip_c = 1'b1;
    end else begin
      y_c = sum[OUT_W-1:0];
    end

    // Stage 0 capture
    v0_d   = bus.ena;
    x0_d   = x0_q;
    ga0_d  = ga0_q;
    gs0_d  = gs0_q;
    cut0_d = cut0_q;
    byp0_d = byp0_q;
    if (bus.ena) begin
      x0_d   = bus.audio_in;
      ga0_d  = bus.attack_gain;
      gs0_d  = bus.sustain_gain;
      cut0_d = bus.sustain_cut;
      byp0_d = bus.bypass;
    end

    // Stage 1 advance
    v1_d   = v0_q;
    x1_d   = x1_q;
    ga1_d  = ga1_q;
    gs1_d  = gs1_q;
    cut1_d = cut1_q;
    byp1_d = byp1_q;
    if (v0_q) begin
      x1_d   = x0_q;
      ga1_d  = ga0_q;
      gs1_d  = gs0_q;
      cut1_d = cut0_q;
      byp1_d = byp0_q;
    end

    // Output stage: audio_out/clip hold between valid samples
    out_valid_d = v1_q;
    audio_out_d = audio_out_q;
    clip_d      = clip_q;
    if (v1_q) begin
      audio_out_d = y_c;
      clip_d      = clip_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      x0_q        <= '0;
      ga0_q       <= '0;
      gs0_q       <= '0;
      cut0_q      <= 1'b0;
      byp0_q      <= 1'b0;
      v1_q        <= 1'b0;
      x1_q        <= '0;
      ga1_q       <= '0;
      gs1_q       <= '0;
      cut1_q      <= 1'b0;
      byp1_q      <= 1'b0;
      env_f_q     <= '0;
      env_s_q     <= '0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      x0_q        <= x0_d;
      ga0_q       <= ga0_d;
      gs0_q       <= gs0_d;
      cut0_q      <= cut0_d;
      byp0_q      <= byp0_d;
      v1_q        <= v1_d;
      x1_q        <= x1_d;
      ga1_q       <= ga1_d;
      gs1_q       <= gs1_d;
      cut1_q      <= cut1_d;
      byp1_q      <= byp1_d;
      env_f_q     <= env_f_d;
      env_s_q     <= env_s_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
    end
  end

  assign bus.audio_out = audio_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.clip      = clip_q;

endmodule

// File: tb/tb_transient_shaper_env.sv
// Directed bench for transient_shaper_env at default parameters.
module tb_transient_shaper_env;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  transient_shaper_env_if #(.IN_W(6), .OUT_W(8), .GAIN_W(3)) bus ();

  transient_shaper_env #(
    .IN_W(6), .OUT_W(8), .FAST_SH(2), .SLOW_SH(5), .GAIN_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] x, input logic [2:0] ga, input logic [2:0] gs,
                       input logic cut, input logic byp);
    bus.ena          = 1'b1;
    bus.audio_in     = x;
    bus.attack_gain  = ga;
    bus.sustain_gain = gs;
    bus.sustain_cut  = cut;
    bus.bypass       = byp;
  endtask

  // One isolated sample; returns just after the edge that registers its output.
  // Gains are scrambled after capture to show they no longer matter.
  task automatic send(input logic [5:0] x, input logic [2:0] ga, input logic [2:0] gs,
                      input logic cut, input logic byp);
    drive(x, ga, gs, cut, byp);
    tick();
    bus.ena          = 1'b0;
    bus.attack_gain  = ~ga;
    bus.sustain_gain = ~gs;
    bus.sustain_cut  = ~cut;
    bus.bypass       = ~byp;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.audio_in = '0;
    bus.attack_gain = '0;
    bus.sustain_gain = '0;
    bus.sustain_cut = 1'b0;
    bus.bypass = 1'b0;
    tick();
    tick();
    chk("rst_audio_out", 32'(bus.audio_out), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_clip",      32'(bus.clip), 0);

    // rst and ena together: sample dropped
    drive(63, 7, 7, 0, 0);
    tick();
    bus.ena = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_ena_valid_n1", 32'(bus.out_valid), 0);
    tick();
    chk("rst_ena_valid_n2", 32'(bus.out_valid), 0);
    chk("rst_ena_out",      32'(bus.audio_out), 0);

    // Zero sample, latency exactly 2
    drive(0, 5, 3, 0, 0);
    tick();
    bus.ena = 1'b0;
    chk("lat_valid_n0", 32'(bus.out_valid), 0);
    tick();
    chk("lat_valid_n1", 32'(bus.out_valid), 0);
    tick();
    chk("lat_valid_n2", 32'(bus.out_valid), 1);
    chk("zero_out",     32'(bus.audio_out), 0);
    chk("zero_clip",    32'(bus.clip), 0);
    tick();
    chk("lat_valid_n3", 32'(bus.out_valid), 0);

    // First transient: env_f=504, env_s=63, tr=14 -> 63+49
    send(63, 7, 0, 0, 0);
    chk("first_tr_valid", 32'(bus.out_valid), 1);
    chk("first_tr_out",   32'(bus.audio_out), 112);
    chk("first_tr_clip",  32'(bus.clip), 0);

    // Bypass still updates envelopes; following sample sees env_f=560, env_s=79
    do_reset();
    send(40, 7, 7, 0, 1);
    chk("bypass_out",  32'(bus.audio_out), 40);
    chk("bypass_clip", 32'(bus.clip), 0);
    send(40, 7, 0, 0, 0);
    chk("post_bypass_out", 32'(bus.audio_out), 92);

    // Gapped stream: 3 idle clocks between samples, outputs hold
    do_reset();
    send(63, 7, 0, 0, 0);
    chk("gap1_out", 32'(bus.audio_out), 112);
    tick();
    chk("gap1_hold_valid", 32'(bus.out_valid), 0);
    chk("gap1_hold_out",   32'(bus.audio_out), 112);
    send(63, 7, 0, 0, 0);
    chk("gap2_out", 32'(bus.audio_out), 147);
    tick();
    chk("gap2_hold_out", 32'(bus.audio_out), 147);
    send(63, 7, 0, 0, 0);
    chk("gap3_out", 32'(bus.audio_out), 171);

    // Steady state x=63 back-to-back, ga=gs=0 passes x through
    do_reset();
    drive(63, 0, 0, 0, 0);
    repeat (300) tick();
    chk("b2b_valid", 32'(bus.out_valid), 1);
    chk("b2b_out",   32'(bus.audio_out), 63);
    tick();
    chk("b2b_valid_cont", 32'(bus.out_valid), 1);
    bus.sustain_gain = 3'd7;
    tick();
    bus.ena = 1'b0;
    bus.sustain_gain = 3'd0;
    tick();
    tick();
    chk("sustain_sat_out",  32'(bus.audio_out), 255);
    chk("sustain_sat_clip", 32'(bus.clip), 1);

    // Sustain cut on the converged envelope (si=63)
    send(63, 0, 1, 1, 0);
    chk("cut1_out",  32'(bus.audio_out), 32);
    chk("cut1_clip", 32'(bus.clip), 0);
    send(63, 0, 2, 1, 0);
    chk("cut2_out",  32'(bus.audio_out), 0);
    chk("cut2_clip", 32'(bus.clip), 0);
    send(63, 7, 7, 0, 1);
    chk("steady_bypass_out", 32'(bus.audio_out), 63);
    send(63, 0, 1, 1, 0);
    chk("cut1_again_out", 32'(bus.audio_out), 32);

    // Reset while a sample is in flight
    drive(63, 0, 7, 0, 0);
    tick();
    bus.ena = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("flight_rst_valid", 32'(bus.out_valid), 0);
    chk("flight_rst_out",   32'(bus.audio_out), 0);
    chk("flight_rst_clip",  32'(bus.clip), 0);

    // Zero gains match bypass from any envelope state
    send(50, 0, 0, 0, 0);
    chk("zero_gain_out", 32'(bus.audio_out), 50);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
